// File: rtl/multi_channel_debouncer.sv
// N-channel key debouncer: per-channel synchroniser, press/release qualification over a stable
// window, registered level and one-cycle pulses. Define AUTOREPEAT_EN to add auto-repeat pulses.
`timescale 1ns/1ps
module multi_channel_debouncer #(
  parameter int unsigned CHANNELS        = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] sig_in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] repeat_pulse,
  output logic                any_held
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StLow, StRiseWait, StHigh, StFallWait} state_t;

  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
    $error("CHANNELS must be 1..32");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 2");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("SYNC_STAGES must be 2..3");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

`ifdef AUTOREPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW = $clog2(RepMax + 1);
  localparam logic [RW-1:0] RepFirstLast = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RepNextLast  = RW'(REPEAT_PERIOD - 1);
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic                   level_q, press_q, release_q;
    logic                   s, cnt_done, press_evt, release_evt;

    assign s           = sync_q[SYNC_STAGES-1];
    assign cnt_done    = (cnt_q == CntLast);
    assign press_evt   = (state_q == StRiseWait) && s && cnt_done;
    assign release_evt = (state_q == StFallWait) && !s && cnt_done;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q    <= '0;
        state_q   <= StLow;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        sync_q    <= {sync_q[SYNC_STAGES-2:0], sig_in[i]};
        press_q   <= 1'b0;
        release_q <= 1'b0;
        unique case (state_q)
          StLow: begin
            if (s) begin
              state_q <= StRiseWait;
              cnt_q   <= '0;
            end
          end
          StRiseWait: begin
            if (!s) begin
              state_q <= StLow;
              cnt_q   <= '0;
            end else if (press_evt) begin
              state_q <= StHigh;
              cnt_q   <= '0;
              level_q <= 1'b1;
              press_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StHigh: begin
            if (!s) begin
              state_q <= StFallWait;
              cnt_q   <= '0;
            end
          end
          StFallWait: begin
            if (s) begin
              state_q <= StHigh;
              cnt_q   <= '0;
            end else if (release_evt) begin
              state_q   <= StLow;
              cnt_q     <= '0;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: state_q <= StLow;
        endcase
      end
    end

    assign level[i]         = level_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = release_q;

`ifdef AUTOREPEAT_EN
    logic [RW-1:0] rcnt_q;
    logic          rfirst_q, rep_q, held;

    assign held = (state_q == StHigh) || (state_q == StFallWait);

    // The edge that leaves for LOW never fires, so the train ends cleanly with the release.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rcnt_q   <= '0;
        rfirst_q <= 1'b0;
        rep_q    <= 1'b0;
      end else begin
        rep_q <= 1'b0;
        if (press_evt) begin
          rcnt_q   <= '0;
          rfirst_q <= 1'b1;
        end else if (!held || release_evt) begin
          rcnt_q   <= '0;
          rfirst_q <= 1'b0;
        end else if (rcnt_q == (rfirst_q ? RepFirstLast : RepNextLast)) begin
          rcnt_q   <= '0;
          rfirst_q <= 1'b0;
          rep_q    <= 1'b1;
        end else begin
          rcnt_q <= rcnt_q + 1'b1;
        end
      end
    end

    assign repeat_pulse[i] = rep_q;
`else
    assign repeat_pulse[i] = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) any_held <= 1'b0;
    else     any_held <= |level;
  end

endmodule

// File: tb/tb_multi_channel_debouncer.sv
// Scoreboard bench for multi_channel_debouncer: expected pulses are queued as stimulus is driven
// and compared every cycle against press/release/repeat outputs.
`timescale 1ns/1ps
module tb_multi_channel_debouncer;
  localparam int CH  = 8;
  localparam int DEB = 4;
  localparam int SYN = 2;
  localparam int LAT = SYN + DEB + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] sig_in = '0;
  logic [CH-1:0] level, press_pulse, release_pulse, repeat_pulse;
  logic          any_held;

  multi_channel_debouncer #(
    .CHANNELS        (CH),
    .DEBOUNCE_CYCLES (DEB),
    .SYNC_STAGES     (SYN),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sig_in        (sig_in),
    .level         (level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .repeat_pulse  (repeat_pulse),
    .any_held      (any_held)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; int ch; int kind;} ev_t;  // kind: 0 press, 1 release, 2 repeat
  ev_t sb[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;
  logic mon_got, mon_want;

  function automatic string kind_name(int k);
    return (k == 0) ? "press_pulse" : (k == 1) ? "release_pulse" : "repeat_pulse";
  endfunction

  task automatic push(int c, int ch, int kind);
    sb.push_back('{cyc: c, ch: ch, kind: kind});
  endtask

  always @(negedge clk) begin
    for (int ch = 0; ch < CH; ch++) begin
      for (int k = 0; k < 3; k++) begin
        mon_want = 1'b0;
        foreach (sb[j]) if (sb[j].cyc == cyc && sb[j].ch == ch && sb[j].kind == k) mon_want = 1'b1;
        mon_got = (k == 0) ? press_pulse[ch] : (k == 1) ? release_pulse[ch] : repeat_pulse[ch];
        if (mon_en) begin
          n_tests++;
          if (mon_got !== mon_want) begin
            n_fail++;
            $display("FAIL %s ch%0d cycle %0d: got %b, expected %b",
                     kind_name(k), ch, cyc, mon_got, mon_want);
          end
        end
      end
    end
    for (int j = sb.size() - 1; j >= 0; j--) if (sb[j].cyc <= cyc) sb.delete(j);
  end

  task automatic wait_to(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, got, exp);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    chk("reset_level", 32'(level), 0);
    chk("reset_press", 32'(press_pulse), 0);
    chk("reset_release", 32'(release_pulse), 0);
    chk("reset_repeat", 32'(repeat_pulse), 0);
    chk("reset_any_held", 32'(any_held), 0);
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_press();
    int e;
    e = cyc;
    sig_in[0] = 1'b1;
    push(e + LAT, 0, 0);
    wait_to(e + LAT - 1);
    chk("press_early_level", 32'(level[0]), 0);
    wait_to(e + LAT);
    chk("press_level", 32'(level[0]), 1);
    chk("press_any_held_lag", 32'(any_held), 0);
    wait_to(e + LAT + 1);
    chk("press_any_held", 32'(any_held), 1);
    chk("press_level_hold", 32'(level[0]), 1);
  endtask

  task automatic test_glitch();
    int e;
    e = cyc;
    sig_in[1] = 1'b1;
    wait_to(e + 3);
    sig_in[1] = 1'b0;
    for (int c = e + 3; c <= e + 14; c++) begin
      wait_to(c);
      chk("glitch_level", 32'(level[1]), 0);
    end
    // A clean press right after must see the full latency, proving the counter restarted.
    e = cyc;
    sig_in[1] = 1'b1;
    push(e + LAT, 1, 0);
    wait_to(e + LAT - 1);
    chk("after_glitch_early", 32'(level[1]), 0);
    wait_to(e + LAT);
    chk("after_glitch_level", 32'(level[1]), 1);
    e = cyc;
    sig_in[1] = 1'b0;
    push(e + LAT, 1, 1);
    wait_to(e + LAT + 1);
    chk("after_glitch_release", 32'(level[1]), 0);
  endtask

  task automatic test_bounce();
    int e, f;
    e = cyc;
    sig_in[0] = 1'b0;
    wait_to(e + 2);
    sig_in[0] = 1'b1;
    wait_to(e + 4);
    sig_in[0] = 1'b0;
    f = e + 4;
    push(f + LAT, 0, 1);
    wait_to(f + LAT - 1);
    chk("bounce_level_held", 32'(level[0]), 1);
    wait_to(f + LAT);
    chk("bounce_level_low", 32'(level[0]), 0);
    wait_to(f + LAT + 3);
  endtask

  function automatic logic [CH-1:0] exp_lv(int c, int e0);
    logic [CH-1:0] v;
    for (int i = 0; i < CH; i++) v[i] = (c >= e0 + i + LAT) && (c < e0 + 20 + (CH - 1 - i) + LAT);
    return v;
  endfunction

  task automatic test_staggered();
    int e0;
    e0 = cyc;
    for (int c = e0; c <= e0 + 45; c++) begin
      wait_to(c);
      chk("stagger_level", 32'(level), 32'(exp_lv(c, e0)));
      chk("stagger_any_held", 32'(any_held), 32'(|exp_lv(c - 1, e0)));
      for (int i = 0; i < CH; i++) begin
        if (c == e0 + i) begin
          sig_in[i] = 1'b1;
          push(c + LAT, i, 0);
        end
        if (c == e0 + 20 + (CH - 1 - i)) begin
          sig_in[i] = 1'b0;
          push(c + LAT, i, 1);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int e, r;
    e = cyc;
    sig_in[5] = 1'b1;
    push(e + LAT, 5, 0);
    wait_to(e + LAT + 2);
    chk("mid_pre_level5", 32'(level[5]), 1);
    chk("mid_pre_any_held", 32'(any_held), 1);
    e = cyc;
    sig_in[2] = 1'b1;
    wait_to(e + 4);
    #2;
    rst    = 1'b1;
    mon_en = 1'b0;
    #1;
    chk("mid_async_level", 32'(level), 0);
    chk("mid_async_any_held", 32'(any_held), 0);
    repeat (2) @(negedge clk);
    chk("mid_hold_press", 32'(press_pulse), 0);
    rst    = 1'b0;
    mon_en = 1'b1;
    r = cyc;
    push(r + LAT, 2, 0);
    push(r + LAT, 5, 0);
    wait_to(r + LAT - 1);
    chk("mid_post_early", 32'(level), 0);
    wait_to(r + LAT);
    chk("mid_post_level", 32'(level), 32'h24);
    e = cyc;
    sig_in[2] = 1'b0;
    sig_in[5] = 1'b0;
    push(e + LAT, 2, 1);
    push(e + LAT, 5, 1);
    wait_to(e + LAT + 2);
    chk("mid_release_level", 32'(level), 0);
  endtask

`ifdef AUTOREPEAT_EN
  task automatic test_repeat();
    int e, p;
    e = cyc;
    p = e + LAT;
    sig_in[3] = 1'b1;
    push(p, 3, 0);
    for (int k = 0; k < 5; k++) push(p + 10 + 4 * k, 3, 2);
    wait_to(e + 30);
    sig_in[3] = 1'b0;
    push(e + 30 + LAT, 3, 1);
    wait_to(p + 29);
    chk("repeat_level_held", 32'(level[3]), 1);
    wait_to(p + 45);
    chk("repeat_level_low", 32'(level[3]), 0);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected to have finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_bounce();
    test_staggered();
    test_reset_mid();
`ifdef AUTOREPEAT_EN
    test_repeat();
`endif
    wait_to(cyc + 10);
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_channel_debouncer.md
Name: multi_channel_debouncer

Overview:
- N-channel parametrised debouncer for the synthesizer's key and button inputs; the next generation after the single-channel press-pulse debouncer.
- Each channel synchronises its raw input, qualifies both press and release edges over a programmable stable window, and outputs a debounced level plus one-cycle press and release pulses.
- Sits between the board pins and the note/voice control logic.
- Optional auto-repeat turns a held key into a periodic pulse train for menu and octave stepping.

Parameters:
- CHANNELS, 8, number of independent input channels (1..32).
- DEBOUNCE_CYCLES, 250000, consecutive stable synchronised samples required to accept an edge (>=2).
- SYNC_STAGES, 2, flip-flops in each input synchroniser (2..3).
- REPEAT_DELAY, 25000000, cycles from accepted press to first repeat pulse (used only with AUTOREPEAT_EN).
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses (used only with AUTOREPEAT_EN).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- sig_in  input  CHANNELS  raw asynchronous key inputs, active-high.
- level  output  CHANNELS  debounced registered state per channel.
- press_pulse  output  CHANNELS  one-cycle pulse on each accepted press.
- release_pulse  output  CHANNELS  one-cycle pulse on each accepted release.
- repeat_pulse  output  CHANNELS  one-cycle auto-repeat pulse; constant 0 without AUTOREPEAT_EN.
- any_held  output  1  OR of all level bits, registered.

Behaviour:
- Reset (async assert, sync release): all synchroniser flops, counters and outputs are 0; every channel is in state LOW.
- Channels are fully independent. Each has its own synchroniser, counter of width clog2(DEBOUNCE_CYCLES) and 2-bit state register.
- s denotes the synchronised input (the last synchroniser stage).
- State LOW, level=0:
  - s=1 -> RISE_WAIT, counter cleared to 0.
- State RISE_WAIT, level=0:
  - s=0 -> LOW (glitch rejected, counter cleared).
  - s=1 and counter = DEBOUNCE_CYCLES-1 -> HIGH; press_pulse=1 on the next cycle only.
  - Otherwise counter increments.
- State HIGH, level=1:
  - s=0 -> FALL_WAIT, counter cleared.
- State FALL_WAIT, level=1:
  - s=1 -> HIGH (glitch rejected).
  - s=0 and counter = DEBOUNCE_CYCLES-1 -> LOW; release_pulse=1 on the next cycle only.
  - Otherwise counter increments.
- Latency from a clean sig_in edge to the level change and pulse is exactly SYNC_STAGES + DEBOUNCE_CYCLES + 1 clocks.
- The level transition and its pulse appear in the same cycle.
- A stable input never produces more than one pulse; press and release pulses never assert together on one channel.
- Any pulse shorter than DEBOUNCE_CYCLES synchronised samples produces no output change.
- Input already high at reset release: treated as a fresh press, reported after the full latency.
- Reset mid-window: the counter is discarded and the channel returns to LOW immediately; a pulse in flight is suppressed.
- any_held follows level with one extra register stage.

Optional Feature:
- Macro: AUTOREPEAT_EN.
- Defined:
  - Each channel has a repeat counter, cleared on entry to HIGH.
  - The first repeat_pulse fires REPEAT_DELAY cycles after press_pulse; further pulses fire every REPEAT_PERIOD cycles while the channel stays in HIGH or FALL_WAIT.
  - The repeat counter stops and clears on entry to LOW.
  - repeat_pulse never coincides with press_pulse.
- Not defined: repeat_pulse is tied to 0 and no repeat counters are synthesised.

Test Plan:
- DEBOUNCE_CYCLES=4, SYNC_STAGES=2; ch0 held high -> level[0] and press_pulse[0] rise exactly 7 clocks after the edge; press_pulse[0] is 1 cycle wide.
- ch1 glitch high for 3 cycles, then low -> no level change and no pulse; counter returns to LOW.
- ch0 high-to-low with a 2-cycle bounce back high inside the window, then stable low -> a single release_pulse[0], 7 clocks after the final edge.
- All 8 channels toggling with staggered edges -> each channel's pulses appear independently; any_held tracks their OR one cycle later.
- rst asserted during ch2 RISE_WAIT -> outputs 0 asynchronously; after release with sig_in[2] still 1, the press is reported 7 clocks after release.
- AUTOREPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=4; ch3 held 30 cycles -> repeat pulses at +10, +14, +18, +22, +26 after press_pulse; none after release.
